// File: rtl/ed_pkg.sv
// Shared types and constants for the energy-difference spike detector.
package ed_pkg;

   localparam int unsigned ENERGY_W       = 32;
   localparam int unsigned DEF_MIN_THRESH = 500;

   typedef enum logic [1:0] {
      ED_IDLE    = 2'd0,
      ED_TRAIN   = 2'd1,
      ED_OPERATE = 2'd2,
      ED_REFRACT = 2'd3
   } ed_state_e;

endpackage : ed_pkg

// File: rtl/ed_calib_accum.sv
// Calibration accumulator: sums 2^LOG2_TRAIN energy samples and offers the
// scaled, saturated and floored threshold alongside a done strobe.
module ed_calib_accum
   import ed_pkg::*;
#(
   parameter int unsigned LOG2_TRAIN  = 6,
   parameter int unsigned SCALE_SHIFT = 2,
   parameter int unsigned MIN_THRESH  = DEF_MIN_THRESH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                valid,
   input  logic [ENERGY_W-1:0] energy,
   output logic                done,
   output logic [ENERGY_W-1:0] thr
);

   localparam int unsigned ACC_W = ENERGY_W + LOG2_TRAIN;
   localparam int unsigned SHL_W = ENERGY_W + SCALE_SHIFT;

   logic [ACC_W-1:0]      r_acc;
   logic [LOG2_TRAIN-1:0] r_cnt;
   logic [ACC_W-1:0]      w_acc_next;
   logic [ENERGY_W-1:0]   w_mean;
   logic [SHL_W-1:0]      w_shl;
   logic [ENERGY_W-1:0]   w_scaled;

   assign w_acc_next = r_acc + ACC_W'(energy);
   assign w_mean     = w_acc_next[LOG2_TRAIN +: ENERGY_W];
   assign w_shl      = SHL_W'(w_mean) << SCALE_SHIFT;
   // Any bit shifted past ENERGY_W means the threshold would wrap, so pin it high.
   assign w_scaled   = ((w_shl >> ENERGY_W) != '0) ? '1 : w_shl[ENERGY_W-1:0];
   assign thr        = (w_scaled < ENERGY_W'(MIN_THRESH)) ? ENERGY_W'(MIN_THRESH) : w_scaled;
   assign done       = valid && (r_cnt == '1);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (clear) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (valid) begin
         r_acc <= done ? '0 : w_acc_next;
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule : ed_calib_accum

// File: rtl/ed_threshold_ctrl.sv
// Spike detector sequencer: calibrate, compare against the adaptive threshold,
// then hold off re-triggering for REFRACT_LEN valid samples.
module ed_threshold_ctrl
   import ed_pkg::*;
#(
   parameter int unsigned LOG2_TRAIN  = 6,
   parameter int unsigned SCALE_SHIFT = 2,
   parameter int unsigned MIN_THRESH  = DEF_MIN_THRESH,
   parameter int unsigned REFRACT_LEN = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                recal,
   input  logic                energy_valid,
   input  logic [ENERGY_W-1:0] energy,
   output logic [ENERGY_W-1:0] threshold,
   output logic                thr_valid,
   output logic                spike_event,
   output logic                training,
   output logic [1:0]          state_o
);

   localparam int unsigned RC_W = $clog2(REFRACT_LEN + 1);

   ed_state_e           r_state;
   logic [ENERGY_W-1:0] r_threshold;
   logic                r_thr_valid;
   logic                r_spike;
   logic                r_training;
   logic [RC_W-1:0]     r_rcnt;
   logic                w_calib_done;
   logic [ENERGY_W-1:0] w_calib_thr;

   // Accumulator stays cleared outside TRAIN, so every calibration starts from zero.
   ed_calib_accum #(
      .LOG2_TRAIN  (LOG2_TRAIN),
      .SCALE_SHIFT (SCALE_SHIFT),
      .MIN_THRESH  (MIN_THRESH)
   ) u_calib (
      .clk    (clk),
      .rst    (rst),
      .clear  (r_state != ED_TRAIN),
      .valid  (energy_valid && (r_state == ED_TRAIN)),
      .energy (energy),
      .done   (w_calib_done),
      .thr    (w_calib_thr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ED_IDLE;
         r_threshold <= ENERGY_W'(MIN_THRESH);
         r_thr_valid <= 1'b0;
         r_spike     <= 1'b0;
         r_training  <= 1'b0;
         r_rcnt      <= '0;
      end else begin
         r_spike <= 1'b0;
         case (r_state)
            ED_IDLE: begin
               if (start) begin
                  r_state    <= ED_TRAIN;
                  r_training <= 1'b1;
               end
            end
            ED_TRAIN: begin
               if (w_calib_done) begin
                  r_threshold <= w_calib_thr;
                  r_thr_valid <= 1'b1;
                  r_state     <= ED_OPERATE;
                  r_training  <= 1'b0;
               end
            end
            ED_OPERATE: begin
               if (recal) begin
                  r_state    <= ED_TRAIN;
                  r_training <= 1'b1;
                  r_rcnt     <= '0;
               end else if (energy_valid && (energy > r_threshold)) begin
                  r_spike <= 1'b1;
                  r_state <= ED_REFRACT;
                  r_rcnt  <= '0;
               end
            end
            ED_REFRACT: begin
               if (recal) begin
                  r_state    <= ED_TRAIN;
                  r_training <= 1'b1;
                  r_rcnt     <= '0;
               end else if (energy_valid) begin
                  if (r_rcnt == RC_W'(REFRACT_LEN - 1)) begin
                     r_state <= ED_OPERATE;
                     r_rcnt  <= '0;
                  end else begin
                     r_rcnt <= r_rcnt + 1'b1;
                  end
               end
            end
            default: r_state <= ED_IDLE;
         endcase
      end
   end

   assign threshold   = r_threshold;
   assign thr_valid   = r_thr_valid;
   assign spike_event = r_spike;
   assign training    = r_training;
   assign state_o     = r_state;

endmodule : ed_threshold_ctrl
